stream_min_reduce: RTL and testbench
====================================

// Module: stream_min_reduce
// PURPOSE
//  Streaming minimum-reduction unit; counterpart of the combinational max partitions.
//  Consumes a frame of unsigned WIDTH-bit words over a valid/ready stream.
//  Returns the frame minimum, plus its position when the index feature is compiled in.
//  Sits downstream of the max partitions, so min/max pairs share one compare style.
// PARAMETERS
//  WIDTH  4                  data word width in bits, unsigned
//  COUNT  8                  maximum beats per frame; frame force-closes at COUNT
//  IDXW   $clog2(COUNT)      index/counter width, derived, do not override
// PORTS
//  clk        in   1      single clock, all logic rising-edge
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      input beat accepted when in_valid & in_ready
//  in_data    in   WIDTH  input word
//  in_last    in   1      marks final beat of frame
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      result consumed when out_valid & out_ready
//  out_min    out  WIDTH  frame minimum
//  out_trunc  out  1      frame closed by COUNT limit, not by in_last
//  out_idx    out  IDXW   beat index of minimum (STREAM_MIN_IDX_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE, beat counter=0.
//    Outputs after reset: out_valid=0, out_min=0, out_trunc=0, out_idx=0, in_ready=1.
//  - FSM IDLE -> ACCUM -> HOLD -> IDLE; in_ready = (state != HOLD), registered.
//  - IDLE: an accepted beat loads min=in_data and idx=0, and sets cnt=1.
//    Next state is ACCUM, or HOLD if that beat has in_last.
//  - ACCUM: each accepted beat updates min only if in_data < min (strict), with idx=cnt.
//    Ties keep the earliest index. cnt increments by 1 per accepted beat.
//  - Frame close, checked on each accepted beat:
//    - in_last=1 -> HOLD, out_trunc=0.
//    - else if the beat was the COUNT-th -> HOLD, out_trunc=1.
//    - If in_last arrives on the COUNT-th beat -> out_trunc=0.
//  - Latency: out_valid rises the cycle after the closing beat is accepted.
//    In HOLD: out_min, out_idx and out_trunc are stable while out_valid=1.
//  - HOLD: on out_valid & out_ready -> IDLE next cycle, out_valid=0.
//    out_min/out_idx keep their last values until the next frame closes.
//    No beat is accepted in the HOLD->IDLE handoff cycle (one-cycle bubble between frames).
//  - in_data is ignored when in_valid=0. Beats presented while in_ready=0 are not consumed.
//  - Reset mid-frame or mid-HOLD discards the partial or pending result; nothing is emitted.
//  - Comparison is unsigned. The counter never wraps: it clears on entering IDLE.
// CONFIGURATION
//  - `STREAM_MIN_IDX_EN defined: out_idx port and index register present, tie rule as above.
//  - Undefined: out_idx port absent, no index register. Min/trunc/handshake timing is identical.
// STRUCTURE
//  - Package stream_min_pkg holds:
//    - state enum (IDLE, ACCUM, HOLD);
//    - DEF_WIDTH=4 and DEF_COUNT=8 constants;
//    - result struct {min, idx, trunc}.
//  - One sub-module: min_cmp_cell (combinational, WIDTH param).
//    Outputs lt = a<b and sel = lt ? a : b. Mirror of the max compare.
//  - Top holds the FSM, counter, result registers and handshake.
// TESTING
//  - Frame 9,3,7,3(last), out_ready=1:
//    -> out_min=3, out_idx=1, out_trunc=0; out_valid 1 cycle after last.
//  - Single-beat frame 5(last):
//    -> out_min=5, out_idx=0. in_ready=0 while HOLD; resumes 1 after handshake.
//  - 8 beats 15,14,..,8 with no in_last:
//    -> out_min=8, out_idx=7, out_trunc=1. The 9th beat starts a new frame.
//  - Hold out_ready=0 for 5 cycles after close:
//    -> out_valid/out_min stable, in_ready=0, no input consumed. Then pulse out_ready.
//  - rst_n=0 after 2 beats of a frame, then new frame 2,1(last):
//    -> out_min=1, out_idx=1. No stale result emitted.
//  - Random in_valid/out_ready gaps, 1000 frames, both macro settings:
//    -> matches a reference model's min/idx/trunc.

Source files
------------

// File: rtl/stream_min_pkg.sv
// Shared types and defaults for the streaming minimum-reduction unit.
package stream_min_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_COUNT = 8;
    localparam int unsigned DEF_IDXW  = $clog2(DEF_COUNT);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] min;
        logic [DEF_IDXW-1:0]  idx;
        logic                 trunc;
    } result_t;

endpackage

// File: rtl/min_cmp_cell.sv
// Unsigned less-than compare cell; passes through the smaller operand, b on ties.
module min_cmp_cell
    import stream_min_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt,
    output logic [WIDTH-1:0] sel
);

    assign lt  = (a < b);
    assign sel = lt ? a : b;

endmodule

// File: rtl/stream_min_reduce.sv
// Streaming frame minimum over a valid/ready input; result held until consumed.
// Define STREAM_MIN_IDX_EN to add the out_idx port reporting the earliest minimum's beat.
module stream_min_reduce
    import stream_min_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned COUNT = DEF_COUNT,
    parameter int unsigned IDXW  = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic             out_trunc
`ifdef STREAM_MIN_IDX_EN
    ,
    output logic [IDXW-1:0]  out_idx
`endif
);

    state_e           state_q, state_d;
    logic [IDXW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_min_q, acc_min_d;
    logic [WIDTH-1:0] res_min_q, res_min_d;
    logic             res_trunc_q, res_trunc_d;
    logic             in_ready_q, out_valid_q;

    logic             accept, first, at_limit, close;
    logic             cmp_lt;
    logic [WIDTH-1:0] cmp_sel, new_min;

    min_cmp_cell #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .a  (in_data),
        .b  (acc_min_q),
        .lt (cmp_lt),
        .sel(cmp_sel)
    );

    assign accept   = in_valid & in_ready_q;
    assign first    = (state_q == StIdle);
    assign at_limit = (cnt_q == IDXW'(COUNT - 1));
    assign close    = accept & (in_last | at_limit);
    assign new_min  = first ? in_data : cmp_sel;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_min_d   = acc_min_q;
        res_min_d   = res_min_q;
        res_trunc_d = res_trunc_q;
        unique case (state_q)
            StIdle, StAccum: begin
                if (accept) begin
                    acc_min_d = new_min;
                    cnt_d     = cnt_q + 1'b1;
                    state_d   = StAccum;
                    if (close) begin
                        state_d     = StHold;
                        cnt_d       = '0;
                        res_min_d   = new_min;
                        res_trunc_d = ~in_last;
                    end
                end
            end
            // out_valid is asserted for the whole of HOLD
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_min_q   <= '0;
            res_min_q   <= '0;
            res_trunc_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_min_q   <= acc_min_d;
            res_min_q   <= res_min_d;
            res_trunc_q <= res_trunc_d;
            in_ready_q  <= (state_d != StHold);
            out_valid_q <= (state_d == StHold);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_min   = res_min_q;
    assign out_trunc = res_trunc_q;

`ifdef STREAM_MIN_IDX_EN
    logic [IDXW-1:0] acc_idx_q, acc_idx_d;
    logic [IDXW-1:0] res_idx_q, res_idx_d;
    logic [IDXW-1:0] new_idx;

    // Strict compare keeps the earliest index on ties
    assign new_idx = first ? '0 : (cmp_lt ? cnt_q : acc_idx_q);

    always_comb begin
        acc_idx_d = acc_idx_q;
        res_idx_d = res_idx_q;
        if (accept) begin
            acc_idx_d = new_idx;
            if (close) begin
                res_idx_d = new_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_idx_q <= '0;
            res_idx_q <= '0;
        end else begin
            acc_idx_q <= acc_idx_d;
            res_idx_q <= res_idx_d;
        end
    end

    assign out_idx = res_idx_q;
`else
    logic unused_lt;
    assign unused_lt = cmp_lt;
`endif

endmodule

// File: tb/tb_stream_min_reduce.sv
// Directed and randomised self-checking bench for stream_min_reduce.
module tb_stream_min_reduce;
    import stream_min_pkg::*;

    localparam int unsigned W = DEF_WIDTH;
    localparam int unsigned N = DEF_COUNT;
    localparam int unsigned IW = DEF_IDXW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_min;
    logic          out_trunc;
    logic [IW-1:0] out_idx;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_min_reduce #(
        .WIDTH(W),
        .COUNT(N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_min  (out_min),
        .out_trunc(out_trunc)
`ifdef STREAM_MIN_IDX_EN
        ,
        .out_idx  (out_idx)
`endif
    );

`ifndef STREAM_MIN_IDX_EN
    assign out_idx = '0;
`endif

    // Called #1 after an edge; returns #1 after the accepting edge with in_valid dropped.
    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL send_beat_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 4'hA;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        if (out_min !== 4'd0) begin failures++; $display("FAIL reset_out_min got=%0d exp=0", out_min); end
        if (out_trunc !== 1'b0) begin failures++; $display("FAIL reset_out_trunc got=%0b exp=0", out_trunc); end
        if (out_idx !== 3'd0) begin failures++; $display("FAIL reset_out_idx got=%0d exp=0", out_idx); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        out_ready = 1'b1;
        send_beat(4'd9, 1'b0);
        send_beat(4'd3, 1'b0);
        send_beat(4'd7, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b exp=0", out_valid); end
        send_beat(4'd3, 1'b1);
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
        if (out_min !== 4'd3) begin failures++; $display("FAIL basic_min got=%0d exp=3", out_min); end
        if (out_trunc !== 1'b0) begin failures++; $display("FAIL basic_trunc got=%0b exp=0", out_trunc); end
`ifdef STREAM_MIN_IDX_EN
        checks++;
        if (out_idx !== 3'd1) begin failures++; $display("FAIL basic_idx_tie got=%0d exp=1", out_idx); end
`endif
        @(posedge clk); #1;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_release got=%0b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_back got=%0b exp=1", in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_single_beat();
        out_ready = 1'b0;
        send_beat(4'd5, 1'b1);
        checks += 3;
        if (out_min !== 4'd5) begin failures++; $display("FAIL single_min got=%0d exp=5", out_min); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL single_ready_hold got=%0b exp=0", in_ready); end
        if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
`ifdef STREAM_MIN_IDX_EN
        checks++;
        if (out_idx !== 3'd0) begin failures++; $display("FAIL single_idx got=%0d exp=0", out_idx); end
`endif
        in_valid = 1'b1; in_data = 4'd1; in_last = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL single_ready_blocked got=%0b exp=0", in_ready); end
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks += 3;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready_resume got=%0b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL single_release got=%0b exp=0", out_valid); end
        if (out_min !== 4'd5) begin failures++; $display("FAIL single_min_kept got=%0d exp=5", out_min); end
    endtask

    task automatic test_trunc_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(4'(15 - i), 1'b0);
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL trunc_valid got=%0b exp=1", out_valid); end
        if (out_min !== 4'd8) begin failures++; $display("FAIL trunc_min got=%0d exp=8", out_min); end
        if (out_trunc !== 1'b1) begin failures++; $display("FAIL trunc_flag got=%0b exp=1", out_trunc); end
`ifdef STREAM_MIN_IDX_EN
        checks++;
        if (out_idx !== 3'd7) begin failures++; $display("FAIL trunc_idx got=%0d exp=7", out_idx); end
`endif
        in_valid = 1'b1; in_data = 4'd0; in_last = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checks += 3;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%0b exp=1", out_valid); end
            if (out_min !== 4'd8) begin failures++; $display("FAIL bp_min got=%0d exp=8", out_min); end
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%0b exp=0", in_ready); end
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%0b exp=0", out_valid); end
        if (out_min !== 4'd8) begin failures++; $display("FAIL bp_min_kept got=%0d exp=8", out_min); end
        // Ninth beat opens a fresh frame
        send_beat(4'd6, 1'b1);
        checks += 2;
        if (out_min !== 4'd6) begin failures++; $display("FAIL ninth_min got=%0d exp=6", out_min); end
        if (out_trunc !== 1'b0) begin failures++; $display("FAIL ninth_trunc got=%0b exp=0", out_trunc); end
`ifdef STREAM_MIN_IDX_EN
        checks++;
        if (out_idx !== 3'd0) begin failures++; $display("FAIL ninth_idx got=%0d exp=0", out_idx); end
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        send_beat(4'd0, 1'b0);
        send_beat(4'd4, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%0b exp=1", in_ready); end
        if (out_min !== 4'd0) begin failures++; $display("FAIL midrst_min got=%0d exp=0", out_min); end
        send_beat(4'd2, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale got=%0b exp=0", out_valid); end
        send_beat(4'd1, 1'b1);
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_new_valid got=%0b exp=1", out_valid); end
        if (out_min !== 4'd1) begin failures++; $display("FAIL midrst_new_min got=%0d exp=1", out_min); end
        if (out_trunc !== 1'b0) begin failures++; $display("FAIL midrst_new_trunc got=%0b exp=0", out_trunc); end
`ifdef STREAM_MIN_IDX_EN
        checks++;
        if (out_idx !== 3'd1) begin failures++; $display("FAIL midrst_new_idx got=%0d exp=1", out_idx); end
`endif
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        result_t exp_q[$];
        result_t exp_r;
        bit      prod_done = 1'b0;
        int      frames = 0;
        int      m_cnt = 0;
        logic [W-1:0] m_min = '0;
        logic [IW-1:0] m_idx = '0;
        fork
            begin
                while (frames < 1000) begin
                    int len = $urandom_range(1, 10);
                    for (int i = 0; i < len; i++) begin
                        logic [W-1:0] d = 4'($urandom_range(0, 15));
                        logic l = (i == len - 1);
                        repeat ($urandom_range(0, 2)) begin
                            in_data = 4'($urandom_range(0, 15));
                            @(posedge clk); #1;
                        end
                        send_beat(d, l);
                        if (m_cnt == 0) begin
                            m_min = d; m_idx = '0;
                        end else if (d < m_min) begin
                            m_min = d; m_idx = 3'(m_cnt);
                        end
                        m_cnt++;
                        if (l || m_cnt == N) begin
                            exp_q.push_back('{min: m_min, idx: m_idx, trunc: !l});
                            m_cnt = 0;
                        end
                    end
                    frames++;
                end
                prod_done = 1'b1;
            end
            begin
                int cyc = 0;
                while (!(prod_done && exp_q.size() == 0) && cyc < 60000) begin
                    @(posedge clk); #2;
                    cyc++;
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL rand_unexpected_result got_min=%0d exp=none", out_min);
                        end else begin
                            exp_r = exp_q.pop_front();
                            checks += 2;
                            if (out_min !== exp_r.min) begin
                                failures++;
                                $display("FAIL rand_min got=%0d exp=%0d", out_min, exp_r.min);
                            end
                            if (out_trunc !== exp_r.trunc) begin
                                failures++;
                                $display("FAIL rand_trunc got=%0b exp=%0b", out_trunc, exp_r.trunc);
                            end
`ifdef STREAM_MIN_IDX_EN
                            checks++;
                            if (out_idx !== exp_r.idx) begin
                                failures++;
                                $display("FAIL rand_idx got=%0d exp=%0d", out_idx, exp_r.idx);
                            end
`endif
                        end
                    end
                end
                if (cyc >= 60000) begin
                    checks++; failures++;
                    $display("FAIL rand_timeout pending=%0d exp=0", exp_q.size());
                end
            end
        join
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
        test_reset();
        @(posedge clk); #1;
        test_basic_frame();
        test_single_beat();
        test_trunc_backpressure();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
